// File: rtl/demux_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_dispatch_pkg
// Purpose  : Shared constants and helpers for the write-back dispatch demux.
//            Holds the datapath width, the default channel count, the slot
//            state encoding and the valid/ready fire helper.
// Revision : 1.0 - initial release
// ============================================================================
package demux_dispatch_pkg;

  localparam int DATA_W        = 32;
  localparam int N_OUT_DEFAULT = 4;

  // Per-slot state encoding; a slot is either holding a word or not.
  localparam logic [0:0] c_slot_empty = 1'b0;
  localparam logic [0:0] c_slot_full  = 1'b1;

  // Saturation value of the drop counter.
  localparam logic [7:0] c_drop_max = 8'hFF;

  // A transfer happens on a side when both valid and ready are high.
  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Purpose  : One-entry holding register for a single dispatch channel.
//            Filled from the shared producer side, drained by its own consumer.
// Ports    : clk, rst_n        - clock / async active-low reset
//            i_fill            - producer transfer addressed to this slot fires
//            i_fill_data       - payload to latch on fill
//            i_ready           - consumer accepts this cycle
//            o_valid           - slot holds a word
//            o_data            - held word (keeps last value after drain)
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fill,
  input  logic [WIDTH-1:0] i_fill_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign o_valid = (r_state == c_slot_full);
  assign o_data  = r_data;
  assign w_drain = fire(o_valid, i_ready);

  // The top only grants a fill when the slot is empty or draining this
  // cycle, so a fill always wins and keeps the slot full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_slot_empty;
      r_data  <= '0;
    end else begin
      case (r_state)
        c_slot_empty: begin
          if (i_fill) begin
            r_state <= c_slot_full;
            r_data  <= i_fill_data;
          end
        end
        c_slot_full: begin
          if (i_fill) begin
            r_data <= i_fill_data;
          end else if (w_drain) begin
            r_state <= c_slot_empty;
          end
        end
        default: r_state <= c_slot_empty;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : demux_dispatch
// Purpose  : Steers one producer stream to one of N_OUT consumers selected
//            per transfer by in_sel. Each channel has a one-entry slot so a
//            stalled consumer only blocks transfers addressed to it.
//            Out-of-range selects are accepted and dropped with a one-cycle
//            sel_err pulse and a saturating drop count.
// Ports    : clk, rst_n                 - clock / async active-low reset
//            in_valid/in_ready/in_data/in_sel - producer handshake
//            out_valid/out_ready/out_data     - per-channel consumer handshake,
//                                               channel k at [k*WIDTH +: WIDTH]
//            sel_err                   - pulse after a dropped transfer
//            drop_cnt                  - saturating dropped-transfer count
// Revision : 1.0 - initial release
// ============================================================================
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N_OUT = N_OUT_DEFAULT,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   sel_err,
  output logic [7:0]             drop_cnt
);

  // One extra bit so N_OUT itself is representable for the range compare.
  localparam logic [SEL_W:0] c_n_out = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0] w_sel_hit;
  logic [N_OUT-1:0] w_slot_open;
  logic [N_OUT-1:0] w_fill;
  logic             w_sel_ok;
  logic             w_in_fire;
  logic             w_drop;
  logic             r_sel_err;
  logic [7:0]       r_drop_cnt;

  assign w_sel_ok = ({1'b0, in_sel} < c_n_out);

  generate
    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
      assign w_sel_hit[k]   = (in_sel == SEL_W'(k));
      // A slot can take a word if empty or if its word leaves this cycle.
      assign w_slot_open[k] = ~out_valid[k] | out_ready[k];
      assign w_fill[k]      = w_in_fire & w_sel_hit[k];

      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fill      (w_fill[k]),
        .i_fill_data (in_data),
        .i_ready     (out_ready[k]),
        .o_valid     (out_valid[k]),
        .o_data      (out_data[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Out-of-range selects are always accepted (and discarded); otherwise
  // readiness follows the addressed slot only, never in_valid.
  assign in_ready  = ~w_sel_ok | (|(w_sel_hit & w_slot_open));
  assign w_in_fire = fire(in_valid, in_ready);
  assign w_drop    = w_in_fire & ~w_sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_sel_err <= w_drop;
      if (w_drop && (r_drop_cnt != c_drop_max)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign sel_err  = r_sel_err;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
